// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, BCD digit constants and a helper that
// returns the smallest digit count able to hold any WIDTH-bit value.
package bin_to_bcd_pkg;

    // Bits per BCD digit
    localparam int unsigned DIGIT_W = 4;

    // Double-dabble correction: digits at or above this threshold get ADJ_ADD
    localparam int unsigned ADJ_THRESH = 5;
    localparam int unsigned ADJ_ADD    = 3;

    // log10(2) scaled by 1e5, used to size the decimal result
    localparam int unsigned LOG10_2_NUM = 30103;
    localparam int unsigned LOG10_2_DEN = 100000;

    // Converter sequencing
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Decimal digits needed for 2^width-1. 2^width is never a power of ten,
    // so this equals floor(width*log10(2)) + 1.
    function automatic int unsigned min_digits(input int unsigned width);
        int unsigned digits;
        if (width == 0) begin
            digits = 1;
        end else begin
            digits = ((width * LOG10_2_NUM) / LOG10_2_DEN) + 1;
        end
        return digits;
    endfunction

endpackage

// File: rtl/bin_to_bcd_digit_adjust.sv
// Combinational double-dabble correction for one BCD digit.
// Ports:
//   digit_i : current scratch digit (0..9 in normal operation)
//   adj_c   : digit + 3 when digit >= 5, else digit unchanged
// Adding 3 before the left shift makes a digit >= 5 carry into the next
// decimal position once it is doubled.
module bcd_digit_adjust
    import bin_to_bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] adj_c
);

    always_comb begin
        adj_c = digit_i;
        if (digit_i >= DIGIT_W'(ADJ_THRESH)) begin
            adj_c = digit_i + DIGIT_W'(ADJ_ADD);
        end
    end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
// A start in IDLE captures bin; WIDTH SHIFT cycles later the FSM enters DONE,
// pulses done for one cycle and updates bcd. bcd holds its value until the
// next done pulse, so downstream seven-segment decoders never see partial
// results.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset (priority over start)
//   start : conversion request, level sensitive, sampled only in IDLE
//   bin   : unsigned binary operand, captured when start is accepted
//   busy  : high whenever the FSM is not in IDLE
//   done  : one-cycle pulse marking a fresh bcd value
//   bcd   : packed BCD result, digit k in bcd[4k+3:4k]
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd
);

    localparam int unsigned BCD_W = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned CAT_W = BCD_W + WIDTH;

    // Reject parameter pairs whose result could overflow the digit field
    if (WIDTH < 1) begin : g_width_err
        $error("bin_to_bcd: WIDTH must be at least 1");
    end
    if (DIGITS < min_digits(WIDTH)) begin : g_digits_err
        $error("bin_to_bcd: DIGITS too small to hold 2^WIDTH-1");
    end

    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   sr_q,      sr_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [BCD_W-1:0]   bcd_q,     bcd_d;
    logic               done_q,    done_d;
    logic               busy_q,    busy_d;

    logic [BCD_W-1:0]   adj_c;
    logic [CAT_W-1:0]   shifted_c;

    // Per-digit add-3 correction on the scratch register
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .adj_c   (adj_c[g*DIGIT_W +: DIGIT_W])
        );
    end

    // One double-dabble step: corrected scratch and operand shifted as one word
    assign shifted_c = {adj_c, sr_q} << 1;

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d      = bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                sr_d      = shifted_c[WIDTH-1:0];
                scratch_d = shifted_c[CAT_W-1:WIDTH];
                cnt_d     = cnt_q + CNT_W'(1);
                // Last shift: publish the finished scratch together with done
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    bcd_d   = shifted_c[CAT_W-1:WIDTH];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule
